// File: rtl/match_window_counter_pkg.sv
// Shared types and default widths for the detection-window counter.
package match_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } win_state_t;

endpackage

// File: rtl/match_window_counter.sv
// Counts detector strobes over programmable windows, reports each window's
// count over valid/ready and raises a sticky alarm on reaching a threshold.
module match_window_counter
  import match_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             z_in,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  input  logic             clr_alarm,
  input  logic             rep_ready,
  output logic             rep_valid,
  output logic [CNT_W-1:0] rep_count,
  output logic             alarm,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HIT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HIT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};

  win_state_t       state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] rep_count_q, rep_count_d;
  logic             alarm_q, alarm_d;
  logic             rep_valid_q, rep_valid_d;
  logic             busy_q, busy_d;

  logic             start_ok;
  logic             last_cyc;
  logic             alarm_set;
  logic [CNT_W-1:0] hit_inc;

  // Next-state, counter and output computation
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    thr_d       = thr_q;
    cyc_d       = cyc_q;
    hit_d       = hit_q;
    rep_count_d = rep_count_q;
    alarm_set   = 1'b0;

    start_ok = en && (window_len != WIN_ZERO);
    last_cyc = (cyc_q == (len_q - WIN_ONE));
    // Saturate rather than wrap so a flooded window still reports the maximum
    if (z_in && (hit_q != HIT_MAX)) begin
      hit_inc = hit_q + HIT_ONE;
    end else begin
      hit_inc = hit_q;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d   = window_len;
          thr_d   = threshold;
          cyc_d   = WIN_ZERO;
          hit_d   = HIT_ZERO;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + WIN_ONE;
          hit_d = hit_inc;
          if (last_cyc) begin
            rep_count_d = hit_inc;
            alarm_set   = (hit_inc >= thr_q);
            state_d     = REPORT;
          end else begin
            state_d = RUN;
          end
        end
      end
      REPORT: begin
        if (rep_ready) begin
          if (start_ok) begin
            len_d   = window_len;
            thr_d   = threshold;
            cyc_d   = WIN_ZERO;
            hit_d   = HIT_ZERO;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REPORT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new alarm in the same cycle as a clear must not be lost
    if (alarm_set) begin
      alarm_d = 1'b1;
    end else if (clr_alarm) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end

    rep_valid_d = (state_d == REPORT);
    busy_d      = (state_d != IDLE);
  end

  // State, counter and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= WIN_ZERO;
      thr_q       <= HIT_ZERO;
      cyc_q       <= WIN_ZERO;
      hit_q       <= HIT_ZERO;
      rep_count_q <= HIT_ZERO;
      alarm_q     <= 1'b0;
      rep_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      thr_q       <= thr_d;
      cyc_q       <= cyc_d;
      hit_q       <= hit_d;
      rep_count_q <= rep_count_d;
      alarm_q     <= alarm_d;
      rep_valid_q <= rep_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rep_valid = rep_valid_q;
  assign rep_count = rep_count_q;
  assign alarm     = alarm_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_match_window_counter.sv
// Directed self-checking bench for match_window_counter.
module tb_match_window_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        z_in;
  logic [15:0] window_len;
  logic [7:0]  threshold;
  logic        clr_alarm;
  logic        rep_ready;
  logic        rep_valid;
  logic [7:0]  rep_count;
  logic        alarm;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  match_window_counter #(.CNT_W(8), .WIN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .z_in       (z_in),
    .window_len (window_len),
    .threshold  (threshold),
    .clr_alarm  (clr_alarm),
    .rep_ready  (rep_ready),
    .rep_valid  (rep_valid),
    .rep_count  (rep_count),
    .alarm      (alarm),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int v, input int c, input int a, input int b);
    check_eq({tag, ".rep_valid"}, int'(rep_valid), v);
    check_eq({tag, ".rep_count"}, int'(rep_count), c);
    check_eq({tag, ".alarm"},     int'(alarm), a);
    check_eq({tag, ".busy"},      int'(busy), b);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; z_in = 1'b0; window_len = 16'd0; threshold = 8'd0;
    clr_alarm = 1'b0; rep_ready = 1'b0;
    step(); step();
    check_outs("reset", 0, 0, 0, 0);
    rst = 1'b0;

    // window_len of zero never starts a window
    en = 1'b1; window_len = 16'd0;
    step();
    check_eq("len0_idle.busy", int'(busy), 0);

    // Basic window: L=10, T=3, hits on cycles 2, 5, 9
    window_len = 16'd10; threshold = 8'd3; rep_ready = 1'b1; z_in = 1'b1;
    step();
    check_eq("basic_entry.busy", int'(busy), 1);
    for (int k = 0; k < 10; k++) begin
      z_in = (k == 2 || k == 5 || k == 9);
      check_eq("basic_run.rep_valid", int'(rep_valid), 0);
      step();
    end
    z_in = 1'b0;
    check_outs("basic_end", 1, 3, 1, 1);
    step();
    check_eq("basic_restart.rep_valid", int'(rep_valid), 0);
    check_eq("basic_restart.busy", int'(busy), 1);

    // Backpressure: same window, report held 6 cycles with pulses dropped
    rep_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      z_in = (k == 2 || k == 5 || k == 9);
      step();
    end
    for (int j = 0; j < 6; j++) begin
      z_in = j[0];
      step();
      check_eq("bp_hold.rep_valid", int'(rep_valid), 1);
      check_eq("bp_hold.rep_count", int'(rep_count), 3);
    end
    z_in = 1'b0; rep_ready = 1'b1;
    step();
    check_eq("bp_restart.rep_valid", int'(rep_valid), 0);
    for (int k = 0; k < 10; k++) begin
      z_in = (k == 4);
      step();
    end
    z_in = 1'b0;
    check_eq("bp_next.rep_count", int'(rep_count), 1);
    check_eq("bp_next.rep_valid", int'(rep_valid), 1);
    en = 1'b0;
    step();
    check_outs("bp_idle", 0, 1, 1, 0);

    // Reset mid-RUN with two hits counted
    en = 1'b1; window_len = 16'd10; threshold = 8'd3;
    step();
    for (int k = 0; k < 5; k++) begin
      z_in = (k == 1 || k == 3);
      step();
    end
    z_in = 1'b0; rst = 1'b1;
    step(); step();
    check_outs("rst_mid", 0, 0, 0, 0);
    rst = 1'b0; en = 1'b0;
    step();
    check_eq("rst_after.busy", int'(busy), 0);

    // Saturation: L=300, z held high, T=200
    en = 1'b1; window_len = 16'd300; threshold = 8'd200; z_in = 1'b1;
    step();
    for (int k = 0; k < 300; k++) step();
    z_in = 1'b0;
    check_outs("sat", 1, 255, 1, 1);
    en = 1'b0;
    step();
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0;
    check_eq("sat_clr.alarm", int'(alarm), 0);

    // Abort at RUN cycle 7 with T=0 that would otherwise alarm
    en = 1'b1; window_len = 16'd20; threshold = 8'd0;
    step();
    for (int k = 0; k < 7; k++) begin
      z_in = (k == 3);
      step();
    end
    z_in = 1'b0; en = 1'b0;
    step();
    check_outs("abort", 0, 255, 0, 0);
    for (int k = 0; k < 15; k++) begin
      step();
      check_eq("abort_quiet.rep_valid", int'(rep_valid), 0);
    end

    // Alarm set and clear collide on the last window cycle
    en = 1'b1; window_len = 16'd6; threshold = 8'd4;
    step();
    for (int k = 0; k < 6; k++) begin
      z_in = (k == 0 || k == 1 || k == 2 || k == 5);
      clr_alarm = (k == 5);
      step();
    end
    z_in = 1'b0; clr_alarm = 1'b0;
    check_outs("collide", 1, 4, 1, 1);
    en = 1'b0;
    step();
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0;
    check_eq("clr_only.alarm", int'(alarm), 0);

    // T=0 with zero hits still alarms
    en = 1'b1; window_len = 16'd3; threshold = 8'd0;
    step();
    for (int k = 0; k < 3; k++) step();
    check_outs("t0", 1, 0, 1, 1);
    en = 1'b0;
    step();
    check_eq("t0_idle.busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Consumes the single-bit Moore detection output `z` of the serial-pattern detector FSM, where `z` is high for exactly one cycle per detected pattern.
- Counts detections over programmable windows of L clock cycles.
- Hands each window's count downstream over a valid/ready report interface.
- Raises a sticky alarm when a window's count reaches a programmable threshold.

Parameters:
- CNT_W, 8, width of hit counter and reported count (saturating)
- WIN_W, 16, width of window length and internal cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  enable windowing; deassert aborts current window
- z_in  in  1  detection strobe from detector FSM
- window_len  in  WIN_W  window length L in cycles; sampled at window start
- threshold  in  CNT_W  alarm threshold; sampled at window start
- clr_alarm  in  1  clears sticky alarm
- rep_ready  in  1  downstream accepts report
- rep_valid  out  1  report available
- rep_count  out  CNT_W  hits in completed window
- alarm  out  1  sticky threshold alarm
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE
  - rep_valid=0, rep_count=0, alarm=0, busy=0
  - internal counters=0
  - rst has priority over every other input, including mid-window and mid-report.
- States: IDLE, RUN, REPORT.
- IDLE:
  - If en=1 and window_len!=0: latch L=window_len and T=threshold, clear cyc_cnt and hit_cnt, go to RUN.
  - If window_len==0: remain in IDLE.
  - z_in is ignored in IDLE, including the transition cycle.
- RUN:
  - Each cycle, cyc_cnt increments.
  - If z_in=1, hit_cnt increments, saturating at 2^CNT_W-1.
  - z_in is sampled as a level, one count per high cycle; the detector guarantees isolated one-cycle pulses.
  - On the cycle where cyc_cnt==L-1:
    - the z_in of that cycle is counted;
    - rep_count <= final hit count;
    - alarm is set if final count >= T (T=0 always alarms);
    - go to REPORT.
  - RUN therefore lasts exactly L cycles.
  - rep_valid rises on the cycle after the last RUN cycle.
  - en=0 in RUN: abort to IDLE next cycle. No report is issued and alarm is not evaluated.
- REPORT:
  - rep_valid=1; rep_count is held stable until the handshake.
  - On rep_valid && rep_ready:
    - if en=1 and window_len!=0, start a new window directly (relatch L and T, clear counters, go to RUN);
    - otherwise go to IDLE.
  - rep_valid drops on the cycle after the handshake.
  - z_in during REPORT is dropped; windows never overlap.
  - en=0 in REPORT does not cancel a pending report.
- alarm:
  - Sticky: cleared by clr_alarm=1.
  - If set and clr_alarm occur in the same cycle, set wins.
- rep_count: retains its last reported value after the handshake and in IDLE, until the next report or reset.
- Width rules:
  - cyc_cnt is WIN_W bits and compares against L-1; L=2^WIN_W-1 is the maximum window.
  - hit_cnt never wraps.

Decomposition:
- Package `match_pkg`:
  - state enum `win_state_t` {IDLE, RUN, REPORT};
  - localparams for default CNT_W/WIN_W.
- No sub-module: the saturating increment and compare are inlined.
- Single always_ff for state/counters plus a combinational next-state block.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles mid-RUN with 2 hits counted.
   - Response: rep_valid=0, rep_count=0, alarm=0, busy=0; state IDLE next cycle.
2. Basic window:
   - Stimulus: L=10, T=3, en=1, rep_ready=1; z_in pulses on RUN cycles 2, 5, 9 (cycle 9 = last).
   - Response: rep_valid high exactly 10 cycles after RUN entry, rep_count=3, alarm=1; new window starts the next cycle.
3. Backpressure:
   - Stimulus: same as test 2 but rep_ready=0 for 6 cycles, with z_in pulses during REPORT.
   - Response: rep_valid held and rep_count=3 stable; the dropped pulses do not appear in the next window's count.
4. Saturation:
   - Stimulus: L=300, z_in held high for the whole window.
   - Response: rep_count=255, alarm=1 for T=200.
5. Abort:
   - Stimulus: L=20, en dropped at RUN cycle 7.
   - Response: busy=0 next cycle, no rep_valid pulse, alarm unchanged.
6. Alarm collision:
   - Stimulus: clr_alarm=1 on the same cycle a window ends with count 4 >= T=4.
   - Response: alarm=1. Then clr_alarm alone → alarm=0 next cycle. T=0 with 0 hits → alarm=1.
